// File: rtl/arbitro_sumador_sg_mag.sv
// Two-port round-robin front end sharing one sign-magnitude adder.
// A granted operand pair is captured in IDLE, summed in CALC and held on
// the response bus in RESP until the consumer takes it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate between requesters, accept one operand pair
// CALC  | single cycle: add captured operands, register the result
// RESP  | rsp_valid high, wait for rsp_ready
module arbitro_sumador_sg_mag #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_res,
   output logic         rsp_ovf,
   output logic         busy
);

   localparam int M = W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic         last_grant;
   logic         grant0;
   logic         grant1;
   logic         hs;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_id;

   logic         sgn_a;
   logic         sgn_b;
   logic [M-1:0] mag_a;
   logic [M-1:0] mag_b;
   logic [M:0]   mag_sum;
   logic [M-1:0] sum_mag;
   logic         sum_sgn;
   logic         sum_ovf;

   // Round-robin grant; only meaningful in IDLE, and a grant implies valid.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign hs         = grant0 | grant1;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);

   // Next-state logic for the IDLE -> CALC -> RESP sequence.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (hs) state_nx = CALC;
         CALC:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Capture the granted operand pair and remember who was served.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_id      <= 1'b0;
      end else if (hs) begin
         last_grant <= grant1;
         op_id      <= grant1;
         op_a       <= grant1 ? req1_a : req0_a;
         op_b       <= grant1 ? req1_b : req0_b;
      end
   end

   // Sign-magnitude add; a zero magnitude always comes out as +0.
   always_comb begin
      sgn_a   = op_a[W-1];
      sgn_b   = op_b[W-1];
      mag_a   = op_a[M-1:0];
      mag_b   = op_b[M-1:0];
      mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
      sum_ovf = 1'b0;
      if (sgn_a == sgn_b) begin
         sum_mag = mag_sum[M-1:0];
         sum_ovf = mag_sum[M];
         sum_sgn = sgn_a;
      end else if (mag_a >= mag_b) begin
         sum_mag = mag_a - mag_b;
         sum_sgn = sgn_a;
      end else begin
         sum_mag = mag_b - mag_a;
         sum_sgn = sgn_b;
      end
      if (sum_mag == '0) sum_sgn = 1'b0;
   end

   // Response registers load only in CALC so they stay put through RESP and after.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_res <= '0;
         rsp_ovf <= 1'b0;
         rsp_id  <= 1'b0;
      end else if (state == CALC) begin
         rsp_res <= {sum_sgn, sum_mag};
         rsp_ovf <= sum_ovf;
         rsp_id  <= op_id;
      end
   end

endmodule
